pulse_handshake_tx: RTL and testbench
=====================================

Name: pulse_handshake_tx

Overview:
- Source-side transmitter of a 4-phase req/ack crossing that moves single-cycle event pulses into a foreign clock domain.
- Converts each event_in pulse into one req_out level transaction. Holds req_out until the remote side's ack_in, which is asynchronous, is seen.
- Queues events that arrive while a transaction is in flight in a saturating pending counter.
- Sits at the sending end of the CDC path. The remote receiver runs a 2-flop level synchronizer on req_out.

Parameters:
- CNT_WIDTH, 4: width of the pending-event counter. Maximum queued events = 2**CNT_WIDTH-1.
- SYNC_STAGES, 2: depth of the internal ack_in synchronizer. Minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- event_in  input  1  single-cycle event strobe; back-to-back strobes are legal.
- ack_in  input  1  asynchronous acknowledge level from the remote domain.
- req_out  output  1  registered request level to the remote domain; glitch-free.
- busy  output  1  high while a transaction is in flight (state != IDLE).
- pending  output  CNT_WIDTH  number of queued events not yet launched.
- tx_done  output  1  one-cycle pulse when a transaction completes (ack returned low).
- overflow  output  1  one-cycle pulse when an event is dropped because pending is saturated.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, req_out=0, pending=0, busy=0, tx_done=0, overflow=0.
  - All synchronizer stages are cleared to 0.
- ack_s is ack_in after SYNC_STAGES flops. Only ack_s is used by the logic.
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - launch = (event_in || pending!=0) && !ack_s.
  - On launch, go to REQ; req_out=1 from the next edge.
  - If ack_s=1 (stale ack), stay in IDLE and keep queuing events.
- REQ:
  - req_out=1.
  - When ack_s=1, go to RELEASE; req_out=0 from the next edge.
- RELEASE:
  - req_out=0.
  - When ack_s=0, assert tx_done for one cycle, go to IDLE, and re-evaluate launch on the following cycle.
- Latency:
  - event_in in IDLE at edge N with pending=0 and ack_s=0 gives req_out=1 after edge N+1.
  - Ack round trip: req_out falls SYNC_STAGES+1 cycles after ack_in rises.
  - tx_done pulses SYNC_STAGES+1 cycles after ack_in falls.
- Pending counter, per cycle:
  - inc = event_in and not consumed directly.
  - dec = launch && pending!=0.
  - An event is consumed directly when it arrives in IDLE with launch true and pending=0; pending stays 0.
  - inc && dec at the same time: pending unchanged.
  - inc at pending = all-ones and no dec: event dropped, pending held, overflow=1 for that cycle.
  - inc with dec at saturation is not an overflow.
- Wrap-around: pending never wraps; it saturates at max and floors at 0.
- No combinational path from any input to any output. req_out, tx_done and overflow are all flop outputs.
- Reset mid-transaction: req_out drops immediately. The remote receiver must be reset in the same reset domain. The block does not recover a half-completed handshake.
- An ack_in glitch shorter than one clk period is not guaranteed to be seen. The protocol requires level acks.

Decomposition:
- Shared package cdc_pkg:
  - typedef enum logic [1:0] hs_state_t {IDLE, REQ, RELEASE}.
  - localparam HS_MIN_SYNC_STAGES = 2.
- Sub-module sync_ff_n (parameter STAGES, async active-low reset, reset value 0):
  - Used for ack_in → ack_s.
  - Reusable by the matching receiver.
- The FSM and counter stay in the top module.

Test Plan:
- Single event: reset, then event_in=1 for 1 cycle with ack looped back through a 3-cycle remote model → req_out rises 1 cycle later; req_out falls 3 cycles after ack_in rises; tx_done pulses once; pending stays 0; busy returns to 0.
- Burst: 5 back-to-back event_in pulses while idle → first consumed directly, pending=4; 5 total req_out transactions; 5 tx_done pulses; pending returns to 0.
- Saturation, CNT_WIDTH=2, ack held low: 5 events → pending=3; overflow pulses exactly once (5th event); remaining 3 queued are launched after ack is released.
- Simultaneous inc/dec: pending=2, event_in asserted on the cycle a launch occurs → pending stays 2.
- Stale ack: ack_in held high across reset release, event_in pulsed → no req_out; pending=1; drop ack_in → req_out=1 on the 3rd edge; pending=0.
- Reset mid-operation: rst_n low while in REQ → req_out, busy, pending and tx_done all 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/cdc_pkg.sv
// cdc_pkg: shared state type and limits for req/ack pulse handshake crossings
package cdc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} hs_state_t;
  localparam int HS_MIN_SYNC_STAGES = 2;
endpackage

// File: rtl/sync_ff_n.sv
// sync_ff_n: N-flop level synchronizer, async active-low reset to 0
module sync_ff_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[STAGES-2:0], d_i};
  assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pulse_handshake_tx.sv
// pulse_handshake_tx: 4-phase req/ack source that launches event pulses into a foreign domain
module pulse_handshake_tx
  import cdc_pkg::*;
#(
  parameter int CNT_WIDTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 event_in,
  input  logic                 ack_in,
  output logic                 req_out,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] pending,
  output logic                 tx_done,
  output logic                 overflow
);
  // a single-flop ack path is never safe, so shallower settings are raised to the minimum
  localparam int SYNC_N = SYNC_STAGES < HS_MIN_SYNC_STAGES ? HS_MIN_SYNC_STAGES : SYNC_STAGES;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  hs_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] pending_q, pending_d;
  logic req_q, req_d, tx_done_q, tx_done_d, overflow_q, overflow_d;
  logic ack_s, has_pend, launch, direct, inc, dec;
  sync_ff_n #(.STAGES(SYNC_N)) u_ack_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (ack_in),
    .q_o  (ack_s)
  );
  always_comb begin
    has_pend   = pending_q != '0;
    launch     = state_q == IDLE && (event_in || has_pend) && !ack_s;
    direct     = launch && !has_pend;
    inc        = event_in && !direct;
    dec        = launch && has_pend;
    state_d    = launch                        ? REQ     :
                 state_q == REQ && ack_s       ? RELEASE :
                 state_q == RELEASE && !ack_s  ? IDLE    : state_q;
    pending_d  = inc == dec             ? pending_q :
                 !inc                   ? pending_q - 1'b1 :
                 pending_q == CNT_MAX   ? pending_q : pending_q + 1'b1;
    overflow_d = inc && !dec && pending_q == CNT_MAX;
    tx_done_d  = state_q == RELEASE && !ack_s;
    req_d      = state_d == REQ;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending_q  <= '0;
      req_q      <= 1'b0;
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      req_q      <= req_d;
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
    end
  assign req_out  = req_q;
  assign busy     = state_q != IDLE;
  assign pending  = pending_q;
  assign tx_done  = tx_done_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_pulse_handshake_tx.sv
// tb_pulse_handshake_tx: directed checks of the handshake source with a 3-cycle remote ack loop
module tb_pulse_handshake_tx;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ev = 1'b0, ack_man = 1'b0, auto_ack = 1'b0;
  logic ack_in, req, busy, done, ovf;
  logic [3:0] pend;
  logic [2:0] ack_p;
  logic s_ev = 1'b0, s_auto = 1'b0;
  logic s_ack_in, s_req, s_busy, s_done, s_ovf;
  logic [1:0] s_pend;
  logic [2:0] s_p;
  int tests = 0, fails = 0;
  int n_done = 0, n_rise = 0, s_done_n = 0, s_ovf_n = 0;
  logic req_prev = 1'b0;
  always #5 clk = ~clk;
  pulse_handshake_tx #(.CNT_WIDTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .event_in(ev), .ack_in(ack_in), .req_out(req),
    .busy(busy), .pending(pend), .tx_done(done), .overflow(ovf)
  );
  pulse_handshake_tx #(.CNT_WIDTH(2), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .event_in(s_ev), .ack_in(s_ack_in), .req_out(s_req),
    .busy(s_busy), .pending(s_pend), .tx_done(s_done), .overflow(s_ovf)
  );
  // remote receiver model: ack follows req three clocks later
  always @(posedge clk or negedge rst_n)
    if (!rst_n) ack_p <= '0;
    else ack_p <= {ack_p[1:0], req};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) s_p <= '0;
    else s_p <= {s_p[1:0], s_req};
  assign ack_in   = auto_ack ? ack_p[2] : ack_man;
  assign s_ack_in = s_auto ? s_p[2] : 1'b0;
  always @(negedge clk) begin
    if (done) n_done++;
    if (req && !req_prev) n_rise++;
    req_prev = req;
  end
  always @(negedge clk) begin
    if (s_done) s_done_n++;
    if (s_ovf) s_ovf_n++;
  end
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_done(input string tag, input bit sat, input int target, input int budget);
    int k = 0;
    while ((sat ? s_done_n : n_done) < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, sat ? s_done_n : n_done, target);
  endtask
  initial begin
    int base, r0, k;
    tick(2);
    check("rst_req", req, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();
    // single event through the remote loop
    auto_ack = 1'b1;
    base = n_done;
    r0 = n_rise;
    ev = 1'b1;
    tick();
    ev = 1'b0;
    check("single_req_rise", req, 1);
    check("single_busy", busy, 1);
    check("single_pend", pend, 0);
    k = 0;
    while (!ack_in && k < 20) begin
      tick();
      k++;
    end
    check("single_ack_seen", ack_in, 1);
    tick(2);
    check("single_req_held", req, 1);
    tick();
    check("single_req_fall", req, 0);
    wait_done("single_done", 1'b0, base + 1, 30);
    tick(5);
    check("single_done_once", n_done - base, 1);
    check("single_rises", n_rise - r0, 1);
    check("single_pend_end", pend, 0);
    check("single_idle", busy, 0);
    // burst of five back-to-back events
    base = n_done;
    r0 = n_rise;
    ev = 1'b1;
    tick(5);
    ev = 1'b0;
    check("burst_pend4", pend, 4);
    wait_done("burst_done", 1'b0, base + 5, 400);
    tick(5);
    check("burst_rises", n_rise - r0, 5);
    check("burst_pend_end", pend, 0);
    check("burst_idle", busy, 0);
    // event on the same cycle a queued launch happens
    auto_ack = 1'b0;
    ack_man = 1'b0;
    base = n_done;
    ev = 1'b1;
    tick(3);
    ev = 1'b0;
    check("simul_pend2", pend, 2);
    ack_man = 1'b1;
    tick(3);
    check("simul_release_req", req, 0);
    check("simul_release_busy", busy, 1);
    ack_man = 1'b0;
    k = 0;
    while (!done && k < 10) begin
      tick();
      k++;
    end
    check("simul_tx_done", done, 1);
    ev = 1'b1;
    tick();
    ev = 1'b0;
    check("simul_pend_held", pend, 2);
    check("simul_relaunch", req, 1);
    auto_ack = 1'b1;
    wait_done("simul_drain", 1'b0, base + 4, 300);
    tick(3);
    check("simul_pend_end", pend, 0);
    // saturation with a 2-bit counter and ack held low
    s_ev = 1'b1;
    tick(5);
    s_ev = 1'b0;
    check("sat_ovf_pulse", s_ovf, 1);
    check("sat_pend3", s_pend, 3);
    tick();
    check("sat_ovf_clear", s_ovf, 0);
    check("sat_ovf_once", s_ovf_n, 1);
    s_auto = 1'b1;
    wait_done("sat_drain", 1'b1, 4, 300);
    tick(3);
    check("sat_pend_end", s_pend, 0);
    check("sat_ovf_total", s_ovf_n, 1);
    // stale ack held across reset release
    auto_ack = 1'b0;
    ack_man = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(3);
    ev = 1'b1;
    tick();
    ev = 1'b0;
    check("stale_no_req", req, 0);
    check("stale_pend1", pend, 1);
    check("stale_idle", busy, 0);
    ack_man = 1'b0;
    tick(2);
    check("stale_req_edge2", req, 0);
    tick();
    check("stale_req_edge3", req, 1);
    check("stale_pend0", pend, 0);
    // asynchronous reset in the middle of a transaction
    ev = 1'b1;
    tick(2);
    ev = 1'b0;
    check("midrst_pend2", pend, 2);
    check("midrst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_req", req, 0);
    check("midrst_busy0", busy, 0);
    check("midrst_pend0", pend, 0);
    check("midrst_done0", done, 0);
    rst_n = 1'b1;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
